// File: rtl/ledmatrix_pkg.sv
// Shared types and helpers for the LED matrix capture block.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
//   cap_state_t   : capture FSM states
//   row_dec_t     : {valid, idx} result of one-hot row decoding
//   frame_t       : [row][col] 8x8 image, active-high pixel on
//   onehot_to_row : one-hot rowdata -> row index, bit7 maps to row 0
package ledmatrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } row_dec_t;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  // The driver's 3-to-8 decoder puts row 0 on bit 7, so the index is
  // mirrored relative to the bit position. valid is high only when exactly
  // one bit is set; idx is meaningless otherwise.
  function automatic row_dec_t onehot_to_row(input logic [7:0] onehot);
    row_dec_t   r;
    logic [3:0] ones;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    ones    = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) begin
        r.idx = 3'(7 - i);
        ones  = ones + 4'd1;
      end
    end
    r.valid = (ones == 4'd1);
    return r;
  endfunction

endpackage

// File: rtl/ledmatrix_capture_row_decode.sv
// One-hot row select decoder for the LED matrix capture block.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//   i_rowdata [7:0] : one-hot row select, bit7 = row 0
//   o_valid         : exactly one bit of i_rowdata is set
//   o_idx     [2:0] : decoded row index (valid only when o_valid)
module ledmatrix_row_decode
  import ledmatrix_pkg::*;
(
  input  logic [7:0] i_rowdata,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  row_dec_t w_dec;

  assign w_dec   = onehot_to_row(i_rowdata);
  assign o_valid = w_dec.valid;
  assign o_idx   = w_dec.idx;

endmodule

// File: rtl/ledmatrix_capture.sv
// Receive end of the 8x8 LED matrix row/column shift interface: rebuilds
// each scanned frame in a work buffer and publishes it on completion of row 7.
// Latency: strobe at cycle N -> work row / frame / frame_valid updated at N+1.
// Backpressure: none; the driver free-runs, i_en = 0 freezes all state.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_en                  : clock enable, strobes ignored while low
//   i_rowdata  [7:0]      : one-hot row select, bit7 = row 0
//   i_coldata  [7:0]      : active-low column data for the selected row
//   i_shiftrow, i_shiftcol: shift strobes, must coincide to form a sample
//   o_frame    [7:0][7:0] : last complete frame, [row][col], 1 = pixel on
//   o_frame_valid         : one-cycle pulse when o_frame is updated
//   o_row_err             : sticky, non-one-hot rowdata on a strobe
//   o_sync_err            : sticky, lone shift strobe or row out of sequence
//   o_gap_err             : sticky, accepted strobes closer than MIN_GAP
//   o_stalled             : no strobe for TIMEOUT cycles
//   o_frame_count [15:0]  : frames published since reset (only with
//                           LEDMATRIX_CAPTURE_STATS_EN defined)
module ledmatrix_capture
  import ledmatrix_pkg::*;
#(
  parameter logic [15:0] MIN_GAP = 16'd10000,
  parameter logic [23:0] TIMEOUT = 24'd200000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [7:0]                 i_rowdata,
  input  logic [7:0]                 i_coldata,
  input  logic                       i_shiftrow,
  input  logic                       i_shiftcol,
  output logic [ROWS-1:0][COLS-1:0]  o_frame,
  output logic                       o_frame_valid,
  output logic                       o_row_err,
  output logic                       o_sync_err,
  output logic                       o_gap_err,
`ifdef LEDMATRIX_CAPTURE_STATS_EN
  output logic [15:0]                o_frame_count,
`endif
  output logic                       o_stalled
);

  // ---------------------------------------------------------------------
  // Strobe qualification and row decode
  // ---------------------------------------------------------------------
  logic       w_strobe;
  logic       w_lone_strobe;
  logic       w_row_vld;
  logic [2:0] w_row_idx;
  logic       w_accept;

  assign w_strobe      = i_en & i_shiftrow & i_shiftcol;
  assign w_lone_strobe = i_en & (i_shiftrow ^ i_shiftcol);

  ledmatrix_row_decode u_row_decode (
    .i_rowdata (i_rowdata),
    .o_valid   (w_row_vld),
    .o_idx     (w_row_idx)
  );

  // A strobe with a malformed row select is a strobe for timeout purposes,
  // but carries no usable sample, so it neither advances the FSM nor
  // restarts the gap measurement.
  assign w_accept = w_strobe & w_row_vld;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  cap_state_t r_state;
  logic [2:0] r_exp;
  frame_t     r_work;
  frame_t     r_frame;
  logic       r_frame_valid;
  logic       r_row_err;
  logic       r_sync_err;
  logic       r_gap_err;
  logic [15:0] r_gap_cnt;
  logic       r_gap_armed;
  logic [23:0] r_to_cnt;

  // Stalled is decoded straight from the saturated timeout counter so it
  // rises the cycle the count reaches TIMEOUT and falls right after the
  // next strobe clears the counter.
  logic w_stalled;
  assign w_stalled = (r_to_cnt == TIMEOUT);

  // ---------------------------------------------------------------------
  // Capture FSM: next state / datapath controls
  // ---------------------------------------------------------------------
  cap_state_t w_state_eff;
  cap_state_t w_state_nxt;
  logic [2:0] w_exp_nxt;
  logic       w_store;
  logic       w_complete;
  logic       w_seq_err;

  // A stall forces IDLE; treating the state as IDLE in the same cycle lets
  // a strobe that coincides with the stall be judged as a fresh start.
  assign w_state_eff = w_stalled ? IDLE : r_state;

  always_comb begin
    w_state_nxt = w_state_eff;
    w_exp_nxt   = r_exp;
    w_store     = 1'b0;
    w_complete  = 1'b0;
    w_seq_err   = 1'b0;
    if (w_accept) begin
      case (w_state_eff)
        IDLE: begin
          // Only row 0 can open a frame; other rows are quietly skipped
          // until the scan wraps around.
          if (w_row_idx == 3'd0) begin
            w_store     = 1'b1;
            w_exp_nxt   = 3'd1;
            w_state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_row_idx == r_exp) begin
            w_store = 1'b1;
            if (r_exp == 3'd7) begin
              w_complete  = 1'b1;
              w_exp_nxt   = 3'd0;
              w_state_nxt = IDLE;
            end else begin
              w_exp_nxt = r_exp + 3'd1;
            end
          end else begin
            w_seq_err = 1'b1;
            if (w_row_idx == 3'd0) begin
              // Driver restarted its scan: resynchronise on this row 0.
              w_store   = 1'b1;
              w_exp_nxt = 3'd1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_exp   <= 3'd0;
    end else if (i_en) begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Work buffer, published frame and completion pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_work        <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (i_en) begin
        if (w_store) begin
          r_work[w_row_idx] <= ~i_coldata;
        end
        if (w_complete) begin
          // Row 7 lands in the work buffer on this same edge, so it is
          // merged from the live column data rather than read back.
          r_frame         <= r_work;
          r_frame[ROWS-1] <= ~i_coldata;
          r_frame_valid   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  logic w_gap_viol;
  assign w_gap_viol = w_accept & r_gap_armed & ~w_stalled & (r_gap_cnt < MIN_GAP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row_err  <= 1'b0;
      r_sync_err <= 1'b0;
      r_gap_err  <= 1'b0;
    end else begin
      if (w_strobe && !w_row_vld) begin
        r_row_err <= 1'b1;
      end
      if (w_lone_strobe || (i_en && w_seq_err)) begin
        r_sync_err <= 1'b1;
      end
      if (w_gap_viol) begin
        r_gap_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Gap and timeout counters
  // ---------------------------------------------------------------------
  // r_gap_armed is clear until the first accepted strobe after reset or
  // after a stall, which exempts that strobe from the spacing check.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gap_cnt   <= 16'd0;
      r_gap_armed <= 1'b0;
      r_to_cnt    <= 24'd0;
    end else if (i_en) begin
      if (w_accept) begin
        r_gap_cnt   <= 16'd0;
        r_gap_armed <= 1'b1;
      end else begin
        if (r_gap_cnt < MIN_GAP) begin
          r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        if (w_stalled) begin
          r_gap_armed <= 1'b0;
        end
      end
      if (w_strobe) begin
        r_to_cnt <= 24'd0;
      end else if (r_to_cnt < TIMEOUT) begin
        r_to_cnt <= r_to_cnt + 24'd1;
      end
    end
  end

`ifdef LEDMATRIX_CAPTURE_STATS_EN
  // ---------------------------------------------------------------------
  // Published-frame counter, wraps naturally at 16 bits
  // ---------------------------------------------------------------------
  logic [15:0] r_frame_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_count <= 16'd0;
    end else if (i_en && w_complete) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_frame_count = r_frame_count;
`endif

  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_row_err     = r_row_err;
  assign o_sync_err    = r_sync_err;
  assign o_gap_err     = r_gap_err;
  assign o_stalled     = w_stalled;

endmodule

// File: tb/tb_ledmatrix_capture.sv
// Self-checking bench for ledmatrix_capture: expected frames are queued as
// row 7 is driven and a negedge monitor pops them on every frame_valid.
// Flags and counts are compared at fixed points of the directed sequence.
module tb_ledmatrix_capture;

  localparam logic [15:0] GAP = 16'd16;
  localparam logic [23:0] TO  = 24'd200;
  localparam int          SP  = 18;   // idle cycles after each row strobe

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [7:0]           rowdata;
  logic [7:0]           coldata;
  logic                 shiftrow;
  logic                 shiftcol;
  logic [7:0][7:0]      frame;
  logic                 frame_valid;
  logic                 row_err;
  logic                 sync_err;
  logic                 gap_err;
  logic                 stalled;
`ifdef LEDMATRIX_CAPTURE_STATS_EN
  logic [15:0]          frame_count;
`endif

  always #5 clk = ~clk;

  ledmatrix_capture #(
    .MIN_GAP (GAP),
    .TIMEOUT (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_rowdata     (rowdata),
    .i_coldata     (coldata),
    .i_shiftrow    (shiftrow),
    .i_shiftcol    (shiftcol),
    .o_frame       (frame),
    .o_frame_valid (frame_valid),
    .o_row_err     (row_err),
    .o_sync_err    (sync_err),
    .o_gap_err     (gap_err),
`ifdef LEDMATRIX_CAPTURE_STATS_EN
    .o_frame_count (frame_count),
`endif
    .o_stalled     (stalled)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  int          exp_fc   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Order: {row_err, sync_err, gap_err, stalled}
  task automatic chk_flags(input string name, input logic [3:0] req);
    chk(name, {60'd0, row_err, sync_err, gap_err, stalled}, {60'd0, req});
  endtask

  function automatic logic [63:0] mk_frame(input logic [7:0] base);
    logic [63:0] f;
    for (int r = 0; r < 8; r++) begin
      f[r*8 +: 8] = base ^ 8'(r);
    end
    return f;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_valid: got frame %0h, want no pulse", frame);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("frame_on_valid", frame, mon_exp);
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] rd, input logic [7:0] cd, input logic sr, input logic sc);
    rowdata  = rd;
    coldata  = cd;
    shiftrow = sr;
    shiftcol = sc;
    @(negedge clk);
    shiftrow = 1'b0;
    shiftcol = 1'b0;
  endtask

  task automatic send_row(input int r, input logic [7:0] pix);
    strobe(8'h80 >> r, ~pix, 1'b1, 1'b1);
    idle(SP);
  endtask

  task automatic send_rows(input logic [7:0] base, input int first, input int last, input bit expect_frame);
    for (int r = first; r <= last; r++) begin
      if (r == 7 && expect_frame) begin
        exp_q.push_back(mk_frame(base));
        exp_fc++;
      end
      send_row(r, base ^ 8'(r));
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    shiftrow = 1'b0;
    shiftcol = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    exp_fc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset with strobes active
    rst = 1'b1; en = 1'b1; rowdata = 8'h80; coldata = 8'h00;
    shiftrow = 1'b1; shiftcol = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; shiftrow = 1'b0; shiftcol = 1'b0; rowdata = 8'h00; coldata = 8'hFF;
    chk("reset_frame", frame, 64'd0);
    chk("reset_valid", 64'(frame_valid), 64'd0);
    chk_flags("reset_flags", 4'b0000);
    chk("reset_pulses", 64'(pulses), 64'd0);
`ifdef LEDMATRIX_CAPTURE_STATS_EN
    chk("reset_count", 64'(frame_count), 64'd0);
`endif

    // 2: clean full frame
    idle(2);
    send_rows(8'hA5, 0, 7, 1'b1);
    idle(2);
    chk_flags("t2_flags", 4'b0000);
    chk("t2_pulses", 64'(pulses), 64'd1);
    chk("t2_frame_hold", frame, mk_frame(8'hA5));

    // 3: malformed row select in the middle of a frame
    do_reset();
    chk("t3_frame_cleared", frame, 64'd0);
    send_rows(8'h3C, 0, 2, 1'b0);
    strobe(8'b0110_0000, 8'h00, 1'b1, 1'b1);
    idle(SP);
    chk_flags("t3_row_err", 4'b1000);
    send_rows(8'h3C, 3, 7, 1'b1);
    idle(2);
    chk_flags("t3_flags_end", 4'b1000);
    chk("t3_pulses", 64'(pulses), 64'd2);

    // 4: out-of-sequence row, then a clean frame
    do_reset();
    send_rows(8'h77, 0, 1, 1'b0);
    send_row(3, 8'h77 ^ 8'd3);
    chk_flags("t4_sync_err", 4'b0100);
    send_rows(8'hC3, 0, 7, 1'b1);
    idle(2);
    chk_flags("t4_flags_end", 4'b0100);
    chk("t4_pulses", 64'(pulses), 64'd3);

    // 4b: lone shift strobe is flagged and its sample ignored
    do_reset();
    strobe(8'h80, ~8'h12, 1'b1, 1'b0);
    idle(SP);
    chk_flags("t4b_lone_strobe", 4'b0100);
    send_rows(8'h12, 1, 7, 1'b0);
    idle(2);
    chk("t4b_pulses", 64'(pulses), 64'd3);

    // 5a: spacing check, first strobe after reset is exempt
    do_reset();
    strobe(8'h80, 8'hF0, 1'b1, 1'b1);
    idle(3);
    chk_flags("t5_first_exempt", 4'b0000);
    strobe(8'h40, 8'hF1, 1'b1, 1'b1);
    idle(2);
    chk_flags("t5_gap_err", 4'b0010);

    // 5b: timeout mid-frame forces IDLE, next strobe clears stalled
    do_reset();
    send_rows(8'hE1, 0, 1, 1'b0);
    idle(int'(TO) - 1 - SP);
    chk_flags("t5_before_timeout", 4'b0000);
    idle(1);
    chk_flags("t5_stalled", 4'b0001);
    send_row(2, 8'hE1 ^ 8'd2);
    chk_flags("t5_unstalled", 4'b0000);
    send_rows(8'hE1, 3, 7, 1'b0);
    idle(2);
    chk("t5_pulses", 64'(pulses), 64'd3);
    chk("t5_frame_held", frame, 64'd0);

    // 6: clock enable low freezes everything
    do_reset();
    en = 1'b0;
    send_rows(8'h99, 0, 7, 1'b0);
    strobe(8'h80, 8'h00, 1'b1, 1'b0);
    idle(int'(TO) + 10);
    chk_flags("t6_en_low_flags", 4'b0000);
    chk("t6_en_low_frame", frame, 64'd0);
    en = 1'b1;
    send_rows(8'h99, 1, 7, 1'b0);
    chk("t6_still_idle", 64'(pulses), 64'd3);
    send_rows(8'h4B, 0, 7, 1'b1);
    send_rows(8'h2D, 0, 7, 1'b1);
    send_rows(8'hF0, 0, 7, 1'b1);
    idle(2);
    chk_flags("t6_flags_end", 4'b0000);
    chk("t6_pulses", 64'(pulses), 64'd6);
    chk("t6_last_frame", frame, mk_frame(8'hF0));
`ifdef LEDMATRIX_CAPTURE_STATS_EN
    chk("t6_frame_count", 64'(frame_count), 64'(exp_fc));
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
